// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder: access types, FSM states
// and the latched request record.
package dm_pkg;

   localparam logic [2:0] DM_WORD   = 3'b000;
   localparam logic [2:0] DM_HALF   = 3'b001;
   localparam logic [2:0] DM_HALF_U = 3'b010;
   localparam logic [2:0] DM_BYTE   = 3'b011;
   localparam logic [2:0] DM_BYTE_U = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  dmtype;
   } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the MEM stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_dmtype;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_dmtype, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_dmtype, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dm_lane_unit.sv
// Little-endian lane handling: load select/extend and store byte-enable merge,
// plus alignment and type legality for the given access.
module dm_lane_unit
   import dm_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic [2:0]  dmtype,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic [31:0] wword,
   output logic        misaligned,
   output logic        bad_type
);

   logic [31:0] shifted;
   logic [31:0] rep;
   logic [3:0]  be;

   always_comb begin
      shifted    = rword >> {lane, 3'b000};
      ldata      = '0;
      rep        = wdata;
      be         = 4'b0000;
      misaligned = 1'b0;
      bad_type   = 1'b0;
      case (dmtype)
         DM_WORD: begin
            ldata      = rword;
            be         = 4'b1111;
            misaligned = (lane != 2'b00);
         end
         DM_HALF, DM_HALF_U: begin
            ldata      = (dmtype == DM_HALF) ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'h0, shifted[15:0]};
            rep        = {2{wdata[15:0]}};
            be         = lane[1] ? 4'b1100 : 4'b0011;
            misaligned = lane[0];
         end
         DM_BYTE, DM_BYTE_U: begin
            ldata = (dmtype == DM_BYTE) ? {{24{shifted[7]}}, shifted[7:0]}
                                        : {24'h0, shifted[7:0]};
            rep   = {4{wdata[7:0]}};
            be    = 4'b0001 << lane;
         end
         default: bad_type = 1'b1;
      endcase
      // Replicated store data lets each lane pick its byte by enable alone.
      for (int i = 0; i < 4; i++)
         wword[8*i +: 8] = be[i] ? rep[8*i +: 8] : rword[8*i +: 8];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one transaction at a time, WAIT_CYCLES wait states,
// access committed on the edge that enters RESP.
module dmem_responder
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 128,
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 7
) (
   input  logic                Clk_CPU,
   input  logic                rstn,
   dmem_responder_if.slave     bus,
   output logic                busy,
   input  logic [ADDR_W-1:0]   dbg_idx,
   output logic [31:0]         dbg_data
);

   localparam logic [7:0] CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

   state_t      state;
   logic [7:0]  cnt;
   req_t        lat_q;
   req_t        in_req;
   req_t        cur;
   logic        req_ready_q, rsp_valid_q, rsp_err_q;
   logic [31:0] rsp_rdata_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic [ADDR_W-1:0] widx;
   logic [31:0] rword, ldata, wword, rdata_n;
   logic        misaligned, bad_type, range_err, err, commit;

   assign in_req = '{we: bus.req_we, addr: bus.req_addr,
                     wdata: bus.req_wdata, dmtype: bus.req_dmtype};
   // With zero wait states the commit happens on the accept edge itself.
   assign cur       = (state == ST_IDLE) ? in_req : lat_q;
   assign widx      = cur.addr[ADDR_W+1:2];
   assign rword     = mem[widx];
   assign range_err = |cur.addr[31:ADDR_W+2];
   assign err       = range_err | misaligned | bad_type;
   assign rdata_n   = (err | cur.we) ? 32'h0 : ldata;
   assign commit    = rstn &&
                      (((state == ST_IDLE) && bus.req_valid && (WAIT_CYCLES == 0)) ||
                       ((state == ST_WAIT) && (cnt == 8'd0)));

   dm_lane_unit u_lane (
      .lane       (cur.addr[1:0]),
      .dmtype     (cur.dmtype),
      .rword      (rword),
      .wdata      (cur.wdata),
      .ldata      (ldata),
      .wword      (wword),
      .misaligned (misaligned),
      .bad_type   (bad_type)
   );

   always_ff @(posedge Clk_CPU)
      if (commit && cur.we && !err)
         mem[widx] <= wword;

   assign dbg_data = mem[dbg_idx];

   always_ff @(posedge Clk_CPU or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         cnt         <= 8'd0;
         lat_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (bus.req_valid) begin
               lat_q       <= in_req;
               req_ready_q <= 1'b0;
               busy        <= 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state       <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rdata_n;
                  rsp_err_q   <= err;
               end else begin
                  state <= ST_WAIT;
                  cnt   <= CNT_INIT;
               end
            end
            ST_WAIT: if (cnt == 8'd0) begin
               state       <= ST_RESP;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= rdata_n;
               rsp_err_q   <= err;
            end else begin
               cnt <= cnt - 8'd1;
            end
            ST_RESP: if (bus.rsp_ready) begin
               state       <= ST_IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_rdata_q <= 32'h0;
               rsp_err_q   <= 1'b0;
               busy        <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a 2-wait-state and a 0-wait-state responder share stimulus;
// table vectors cover load/store/error cases, hand sequences the corner cases.
module tb_dmem_responder;
   import dm_pkg::*;

   logic        Clk_CPU = 1'b0;
   logic        rstn;
   logic        req_valid, req_we, rsp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_dmtype;
   logic [6:0]  dbg_idx;
   logic [31:0] dbg_data0, dbg_data1;
   logic        busy0, busy1;

   int total = 0;
   int bad   = 0;

   always #5 Clk_CPU = ~Clk_CPU;

   dmem_responder_if bus0 ();
   dmem_responder_if bus1 ();

   assign bus0.req_valid  = req_valid;
   assign bus0.req_we     = req_we;
   assign bus0.req_addr   = req_addr;
   assign bus0.req_wdata  = req_wdata;
   assign bus0.req_dmtype = req_dmtype;
   assign bus0.rsp_ready  = rsp_ready;
   assign bus1.req_valid  = req_valid;
   assign bus1.req_we     = req_we;
   assign bus1.req_addr   = req_addr;
   assign bus1.req_wdata  = req_wdata;
   assign bus1.req_dmtype = req_dmtype;
   assign bus1.rsp_ready  = rsp_ready;

   dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2), .ADDR_W(7)) dut0 (
      .Clk_CPU (Clk_CPU), .rstn (rstn), .bus (bus0.slave),
      .busy (busy0), .dbg_idx (dbg_idx), .dbg_data (dbg_data0));

   dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0), .ADDR_W(7)) dut1 (
      .Clk_CPU (Clk_CPU), .rstn (rstn), .bus (bus1.slave),
      .busy (busy1), .dbg_idx (dbg_idx), .dbg_data (dbg_data1));

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  dmt;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        chk;
      logic [6:0]  widx;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " req_ready"}, {31'h0, bus0.req_ready}, 32'h1);
      chk({tag, " rsp_valid"}, {31'h0, bus0.rsp_valid}, 32'h0);
      chk({tag, " rsp_rdata"}, bus0.rsp_rdata, 32'h0);
      chk({tag, " rsp_err"},   {31'h0, bus0.rsp_err}, 32'h0);
      chk({tag, " busy"},      {31'h0, busy0}, 32'h0);
   endtask

   // Issue one request from a negedge; lat counts edges after the accept
   // edge until rsp_valid is seen, i.e. rsp_valid is first sampled at N+1+lat.
   task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] dmt,
                         output logic [31:0] rdata, output logic err, output int lat);
      int n;
      logic rdy, vld;
      req_we = we; req_addr = addr; req_wdata = wdata; req_dmtype = dmt;
      req_valid = 1'b1; rsp_ready = 1'b1;
      rdata = 32'h0; err = 1'b0; lat = -1;
      n = 0;
      rdy = sel ? bus1.req_ready : bus0.req_ready;
      while (!rdy && n < 20) begin
         @(negedge Clk_CPU); n++;
         rdy = sel ? bus1.req_ready : bus0.req_ready;
      end
      if (!rdy) begin
         total++; bad++;
         $display("FAIL accept timeout addr=%h", addr);
         req_valid = 1'b0;
         return;
      end
      @(posedge Clk_CPU); #1 req_valid = 1'b0;
      n = 0;
      forever begin
         @(negedge Clk_CPU);
         vld = sel ? bus1.rsp_valid : bus0.rsp_valid;
         if (vld || n >= 20) break;
         @(posedge Clk_CPU); n++;
      end
      if (!vld) begin
         total++; bad++;
         $display("FAIL response timeout addr=%h", addr);
         return;
      end
      lat   = n;
      rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
      err   = sel ? bus1.rsp_err : bus0.rsp_err;
      @(negedge Clk_CPU);
   endtask

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] dmt, input logic [31:0] er, input logic ee,
                               input logic c, input logic [6:0] wi, input logic [31:0] ew);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.dmt = dmt;
      v.exp_rdata = er; v.exp_err = ee; v.chk = c; v.widx = wi; v.exp_word = ew;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      vecs[0]  = mk(1, 32'h10,  32'hDEADBEEF, DM_WORD,   32'h0,        0, 1, 7'd4,   32'hDEADBEEF);
      vecs[1]  = mk(0, 32'h13,  32'h0,        DM_BYTE,   32'hFFFFFFDE, 0, 0, 7'd0,   32'h0);
      vecs[2]  = mk(0, 32'h13,  32'h0,        DM_BYTE_U, 32'h000000DE, 0, 0, 7'd0,   32'h0);
      vecs[3]  = mk(0, 32'h12,  32'h0,        DM_HALF,   32'hFFFFDEAD, 0, 0, 7'd0,   32'h0);
      vecs[4]  = mk(0, 32'h10,  32'h0,        DM_HALF_U, 32'h0000BEEF, 0, 0, 7'd0,   32'h0);
      vecs[5]  = mk(1, 32'h11,  32'h000000AA, DM_BYTE,   32'h0,        0, 1, 7'd4,   32'hDEADAAEF);
      vecs[6]  = mk(0, 32'h10,  32'h0,        DM_WORD,   32'hDEADAAEF, 0, 0, 7'd0,   32'h0);
      vecs[7]  = mk(0, 32'h12,  32'h0,        DM_WORD,   32'h0,        1, 1, 7'd4,   32'hDEADAAEF);
      vecs[8]  = mk(1, 32'h11,  32'h00005555, DM_HALF,   32'h0,        1, 1, 7'd4,   32'hDEADAAEF);
      vecs[9]  = mk(0, 32'h200, 32'h0,        DM_WORD,   32'h0,        1, 0, 7'd0,   32'h0);
      vecs[10] = mk(0, 32'h10,  32'h0,        3'b111,    32'h0,        1, 0, 7'd0,   32'h0);
      vecs[11] = mk(1, 32'h12,  32'h00001234, DM_HALF,   32'h0,        0, 1, 7'd4,   32'h1234AAEF);
      vecs[12] = mk(0, 32'h12,  32'h0,        DM_HALF,   32'h00001234, 0, 0, 7'd0,   32'h0);
      vecs[13] = mk(0, 32'h10,  32'h0,        DM_BYTE,   32'hFFFFFFEF, 0, 0, 7'd0,   32'h0);
      vecs[14] = mk(1, 32'h20,  32'h0BADF00D, DM_WORD,   32'h0,        0, 1, 7'd8,   32'h0BADF00D);
      vecs[15] = mk(1, 32'h1FC, 32'h80000001, DM_WORD,   32'h0,        0, 1, 7'd127, 32'h80000001);

      rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_dmtype = DM_WORD; dbg_idx = 7'd0;
      repeat (3) @(posedge Clk_CPU);
      @(negedge Clk_CPU);
      chk_reset("reset");
      rstn = 1'b1;
      @(negedge Clk_CPU);

      for (int i = 0; i < 16; i++) begin
         do_req(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].dmt, rd, er, lat);
         chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("v%0d err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
         chk($sformatf("v%0d latency", i), 32'(lat), 32'd2);
         if (vecs[i].chk) begin
            dbg_idx = vecs[i].widx; #1;
            chk($sformatf("v%0d dbg word", i), dbg_data0, vecs[i].exp_word);
         end
      end

      // Back-pressure: response held, a competing store must not be taken.
      req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_dmtype = DM_WORD;
      req_valid = 1'b1; rsp_ready = 1'b0;
      @(posedge Clk_CPU);
      #1 req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
      begin
         int n = 0;
         @(negedge Clk_CPU);
         while (!bus0.rsp_valid && n < 10) begin @(negedge Clk_CPU); n++; end
      end
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d rsp_valid", k), {31'h0, bus0.rsp_valid}, 32'h1);
         chk($sformatf("bp%0d rsp_rdata", k), bus0.rsp_rdata, 32'h1234AAEF);
         chk($sformatf("bp%0d req_ready", k), {31'h0, bus0.req_ready}, 32'h0);
         @(negedge Clk_CPU);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge Clk_CPU);
      chk("bp release rsp_valid", {31'h0, bus0.rsp_valid}, 32'h0);
      chk("bp release req_ready", {31'h0, bus0.req_ready}, 32'h1);
      chk("bp release busy", {31'h0, busy0}, 32'h0);
      dbg_idx = 7'd8; #1;
      chk("bp word8 untouched", dbg_data0, 32'h0BADF00D);

      // Reset while the store sits in WAIT: dropped with no write.
      @(negedge Clk_CPU);
      req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_dmtype = DM_WORD;
      req_valid = 1'b1;
      @(posedge Clk_CPU);
      #1 req_valid = 1'b0;
      @(negedge Clk_CPU);
      chk("wait busy", {31'h0, busy0}, 32'h1);
      rstn = 1'b0; #1;
      chk_reset("midreset");
      @(posedge Clk_CPU);
      @(negedge Clk_CPU);
      rstn = 1'b1;
      repeat (3) @(negedge Clk_CPU);
      dbg_idx = 7'd8; #1;
      chk("midreset word8", dbg_data0, 32'h0BADF00D);
      chk("midreset req_ready", {31'h0, bus0.req_ready}, 32'h1);

      // Zero-wait-state build.
      do_req(1, 1'b0, 32'h10, 32'h0, DM_WORD, rd, er, lat);
      chk("w0 lw rdata", rd, 32'h1234AAEF);
      chk("w0 lw latency", 32'(lat), 32'd0);
      do_req(1, 1'b1, 32'h40, 32'h55AA55AA, DM_WORD, rd, er, lat);
      chk("w0 sw err", {31'h0, er}, 32'h0);
      do_req(1, 1'b0, 32'h41, 32'h0, DM_BYTE_U, rd, er, lat);
      chk("w0 lbu rdata", rd, 32'h00000055);
      chk("w0 lbu latency", 32'(lat), 32'd0);
      dbg_idx = 7'd16; #1;
      chk("w0 dbg word16", dbg_data1, 32'h55AA55AA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
